// File: rtl/tx_fifo_bridge.sv
// tx_fifo_bridge: pops words from a first-word-fall-through async FIFO and
// launches them one at a time into a UART transmitter, waiting for the
// transmitter's busy handshake, with a busy-rise timeout and an inter-frame gap.
module tx_fifo_bridge #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 255,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic                  tx_clk,
  input  logic                  uart_sync_rst,
  input  logic                  tx_enable,
  input  logic                  empty_flag,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  busy,
  output logic                  rd_inc,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_data_valid,
  output logic [15:0]           frame_count,
  output logic                  timeout_err,
  output logic                  bridge_idle
);

  localparam int unsigned TW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(BUSY_TIMEOUT);
  localparam logic [GW-1:0] GAP_LAST    = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t                state_q;
  logic                  rd_inc_q;
  logic [DATA_WIDTH-1:0] tx_p_data_q;
  logic                  tx_data_valid_q;
  logic [15:0]           frame_count_q;
  logic [15:0]           frame_count_d;
  logic                  timeout_err_q;
  logic                  bridge_idle_q;
  logic [TW-1:0]         wait_cnt_q;
  logic [TW-1:0]         wait_cnt_d;
  logic [GW-1:0]         gap_cnt_q;
  logic [GW-1:0]         gap_cnt_d;
  logic                  fetch_ok;

  // Incremented counter values and the IDLE fetch qualifier.
  always_comb begin
    wait_cnt_d    = wait_cnt_q + 1'b1;
    gap_cnt_d     = gap_cnt_q + 1'b1;
    frame_count_d = frame_count_q + 16'd1;
    fetch_ok      = tx_enable && !empty_flag && !busy;
  end

  // Frame sequencer; every output is registered and bridge_idle is updated
  // on the same edge that enters or leaves IDLE, so it always mirrors the state.
  always_ff @(posedge tx_clk or negedge uart_sync_rst) begin
    if (!uart_sync_rst) begin
      state_q         <= S_IDLE;
      rd_inc_q        <= 1'b0;
      tx_p_data_q     <= '0;
      tx_data_valid_q <= 1'b0;
      frame_count_q   <= '0;
      timeout_err_q   <= 1'b0;
      bridge_idle_q   <= 1'b1;
      wait_cnt_q      <= '0;
      gap_cnt_q       <= '0;
    end else begin
      rd_inc_q        <= 1'b0;
      tx_data_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fetch_ok) begin
            // Word and pop strobe are registered on entry so both are seen during LOAD.
            state_q       <= S_LOAD;
            tx_p_data_q   <= fifo_rd_data;
            rd_inc_q      <= 1'b1;
            bridge_idle_q <= 1'b0;
          end
        end
        S_LOAD: begin
          state_q         <= S_LAUNCH;
          tx_data_valid_q <= 1'b1;
        end
        S_LAUNCH: begin
          state_q    <= S_WAIT_BUSY;
          wait_cnt_q <= '0;
        end
        S_WAIT_BUSY: begin
          if (busy) begin
            // busy takes priority over a timeout reached in the same cycle.
            state_q       <= S_WAIT_DONE;
            frame_count_q <= frame_count_d;
            wait_cnt_q    <= '0;
          end else if (wait_cnt_d == TIMEOUT_VAL) begin
            state_q       <= S_IDLE;
            timeout_err_q <= 1'b1;
            bridge_idle_q <= 1'b1;
            wait_cnt_q    <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_WAIT_DONE: begin
          if (!busy) begin
            if (GAP_CYCLES == 0) begin
              state_q       <= S_IDLE;
              bridge_idle_q <= 1'b1;
            end else begin
              state_q   <= S_GAP;
              gap_cnt_q <= '0;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q       <= S_IDLE;
            bridge_idle_q <= 1'b1;
            gap_cnt_q     <= '0;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          bridge_idle_q <= 1'b1;
          wait_cnt_q    <= '0;
          gap_cnt_q     <= '0;
        end
      endcase
    end
  end

  assign rd_inc        = rd_inc_q;
  assign tx_p_data     = tx_p_data_q;
  assign tx_data_valid = tx_data_valid_q;
  assign frame_count   = frame_count_q;
  assign timeout_err   = timeout_err_q;
  assign bridge_idle   = bridge_idle_q;

endmodule

// File: tb/tb_tx_fifo_bridge.sv
// tb_tx_fifo_bridge: directed checks of tx_fifo_bridge with a small FWFT FIFO
// model driving empty_flag/fifo_rd_data and hand-driven busy.
module tb_tx_fifo_bridge;

  logic        tx_clk = 1'b0;
  logic        uart_sync_rst = 1'b1;
  logic        tx_enable;
  logic        empty_flag;
  logic [7:0]  fifo_rd_data;
  logic        busy;
  logic        rd_inc;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic [15:0] frame_count;
  logic        timeout_err;
  logic        bridge_idle;

  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          rd_seen = 0;
  logic [7:0]  fifo_q[$];

  tx_fifo_bridge #(
    .DATA_WIDTH  (8),
    .BUSY_TIMEOUT(255),
    .GAP_CYCLES  (1)
  ) dut (
    .tx_clk       (tx_clk),
    .uart_sync_rst(uart_sync_rst),
    .tx_enable    (tx_enable),
    .empty_flag   (empty_flag),
    .fifo_rd_data (fifo_rd_data),
    .busy         (busy),
    .rd_inc       (rd_inc),
    .tx_p_data    (tx_p_data),
    .tx_data_valid(tx_data_valid),
    .frame_count  (frame_count),
    .timeout_err  (timeout_err),
    .bridge_idle  (bridge_idle)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic update_fifo();
    empty_flag   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    update_fifo();
  endtask

  // Advance one cycle; sample 1 time unit after the edge. The FIFO pops on
  // the edge that ends a cycle with rd_inc high.
  task automatic tick();
    logic pop;
    pop = rd_inc;
    @(posedge tx_clk);
    #1;
    cyc++;
    if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    update_fifo();
    if (rd_inc) begin
      rd_seen++;
      check("rd_while_empty", 32'(empty_flag), 0);
    end
  endtask

  task automatic wait_launch(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tx_data_valid) break;
      tick();
    end
    check("launch_seen", 32'(tx_data_valid), 1);
  endtask

  logic [7:0] b2b_words[3];
  int         drop_cyc;
  int         launch_cyc;

  initial begin
    tx_enable = 1'b0;
    busy      = 1'b0;
    update_fifo();
    b2b_words[0] = 8'h11;
    b2b_words[1] = 8'h22;
    b2b_words[2] = 8'h33;

    // Reset values
    #1 uart_sync_rst = 1'b0;
    #1;
    check("rst_rd_inc", 32'(rd_inc), 0);
    check("rst_valid", 32'(tx_data_valid), 0);
    check("rst_pdata", 32'(tx_p_data), 0);
    check("rst_fcount", 32'(frame_count), 0);
    check("rst_terr", 32'(timeout_err), 0);
    check("rst_idle", 32'(bridge_idle), 1);
    repeat (3) tick();
    uart_sync_rst = 1'b1;
    tick();
    check("post_rst_idle", 32'(bridge_idle), 1);

    // Single frame 0xA5, busy held 10 cycles
    tx_enable = 1'b1;
    rd_seen   = 0;
    tick();
    tick();
    push(8'hA5);
    tick();
    check("s_rd_inc", 32'(rd_inc), 1);
    check("s_pdata_load", 32'(tx_p_data), 'hA5);
    check("s_valid_early", 32'(tx_data_valid), 0);
    tick();
    check("s_valid", 32'(tx_data_valid), 1);
    check("s_pdata_launch", 32'(tx_p_data), 'hA5);
    check("s_rd_once", 32'(rd_inc), 0);
    tick();
    check("s_valid_once", 32'(tx_data_valid), 0);
    busy = 1'b1;
    repeat (10) tick();
    check("s_fcount", 32'(frame_count), 1);
    busy = 1'b0;
    tick();
    check("s_gap_not_idle", 32'(bridge_idle), 0);
    tick();
    check("s_idle_after_gap", 32'(bridge_idle), 1);
    check("s_pdata_hold", 32'(tx_p_data), 'hA5);
    check("s_rd_count", 32'(rd_seen), 1);

    // Back-to-back 0x11/0x22/0x33
    rd_seen  = 0;
    drop_cyc = 0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    for (int i = 0; i < 3; i++) begin
      wait_launch(20);
      check("b2b_data", 32'(tx_p_data), 32'(b2b_words[i]));
      if (i > 0) check("b2b_gap", 32'(cyc - drop_cyc), 4);
      tick();
      busy = 1'b1;
      repeat (3) tick();
      busy = 1'b0;
      drop_cyc = cyc;
    end
    repeat (6) tick();
    check("b2b_rd_count", 32'(rd_seen), 3);
    check("b2b_fcount", 32'(frame_count), 4);
    check("b2b_idle", 32'(bridge_idle), 1);

    // busy rising in the 255th wait cycle wins over the timeout
    push(8'h5A);
    wait_launch(20);
    repeat (255) tick();
    busy = 1'b1;
    tick();
    check("edge_terr", 32'(timeout_err), 0);
    check("edge_fcount", 32'(frame_count), 5);
    busy = 1'b0;
    repeat (4) tick();
    check("edge_idle", 32'(bridge_idle), 1);

    // busy never rises: timeout
    push(8'hC3);
    wait_launch(20);
    launch_cyc = cyc;
    repeat (255) tick();
    check("to_terr_early", 32'(timeout_err), 0);
    check("to_not_idle", 32'(bridge_idle), 0);
    tick();
    check("to_delay", 32'(cyc - launch_cyc), 256);
    check("to_terr", 32'(timeout_err), 1);
    check("to_idle", 32'(bridge_idle), 1);
    check("to_fcount", 32'(frame_count), 5);
    repeat (20) tick();
    check("to_sticky", 32'(timeout_err), 1);

    // Reset asserted during WAIT_DONE
    push(8'h77);
    wait_launch(20);
    tick();
    busy = 1'b1;
    repeat (3) tick();
    check("mid_busy_state", 32'(bridge_idle), 0);
    uart_sync_rst = 1'b0;
    #1;
    check("mid_rd_inc", 32'(rd_inc), 0);
    check("mid_valid", 32'(tx_data_valid), 0);
    check("mid_pdata", 32'(tx_p_data), 0);
    check("mid_fcount", 32'(frame_count), 0);
    check("mid_terr", 32'(timeout_err), 0);
    check("mid_idle", 32'(bridge_idle), 1);
    tick();
    uart_sync_rst = 1'b1;
    busy    = 1'b0;
    rd_seen = 0;
    repeat (20) tick();
    check("mid_no_rd", 32'(rd_seen), 0);

    // Enable / empty gating, enable dropped mid-frame
    rd_seen = 0;
    repeat (50) tick();
    check("gate_empty", 32'(rd_seen), 0);
    tx_enable = 1'b0;
    push(8'h3C);
    repeat (100) tick();
    check("gate_disabled", 32'(rd_seen), 0);
    check("gate_idle", 32'(bridge_idle), 1);
    tx_enable = 1'b1;
    wait_launch(20);
    check("en_pdata", 32'(tx_p_data), 'h3C);
    tx_enable = 1'b0;
    push(8'h4D);
    tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    repeat (30) tick();
    check("en_fcount", 32'(frame_count), 1);
    check("en_rd_count", 32'(rd_seen), 1);
    check("en_idle", 32'(bridge_idle), 1);

    // frame_count wrap from 0xFFFF
    force dut.frame_count_q = 16'hFFFF;
    tick();
    release dut.frame_count_q;
    tx_enable = 1'b1;
    wait_launch(20);
    check("wrap_pdata", 32'(tx_p_data), 'h4D);
    tick();
    busy = 1'b1;
    tick();
    check("wrap_fcount", 32'(frame_count), 0);
    busy = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/tx_fifo_bridge.md
TX_FIFO_BRIDGE -- requirements
Module: tx_fifo_bridge

Interface
REQ-001 Parameter DATA_WIDTH SHALL be provided, default 8, setting the width of the FIFO read data and TX parallel data.
REQ-002 Parameter BUSY_TIMEOUT SHALL be provided, default 255, giving the maximum number of tx_clk cycles to wait for busy to rise after launch.
REQ-003 Parameter GAP_CYCLES SHALL be provided, default 1, giving the number of idle tx_clk cycles inserted between frames.
REQ-004 tx_clk  input  1  bridge clock (UART TX divided clock); all logic is posedge.
REQ-005 uart_sync_rst  input  1  reset, asynchronous, active-low.
REQ-006 tx_enable  input  1  permits fetching new frames when high.
REQ-007 empty_flag  input  1  async FIFO empty, synchronous to tx_clk.
REQ-008 fifo_rd_data  input  DATA_WIDTH  FIFO head word (first-word-fall-through).
REQ-009 busy  input  1  UART TX frame-in-progress.
REQ-010 rd_inc  output  1  FIFO pop strobe, one cycle.
REQ-011 tx_p_data  output  DATA_WIDTH  registered word presented to UART TX.
REQ-012 tx_data_valid  output  1  one-cycle launch strobe to UART TX.
REQ-013 frame_count  output  16  count of frames accepted by UART TX.
REQ-014 timeout_err  output  1  sticky flag: busy never rose after a launch.
REQ-015 bridge_idle  output  1  high when the FSM is in IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, LAUNCH, WAIT_BUSY, WAIT_DONE and GAP.
REQ-017 IDLE SHALL go to LOAD when tx_enable=1, empty_flag=0 and busy=0 are all sampled in the same cycle; otherwise it SHALL stay in IDLE.
REQ-018 In LOAD, tx_p_data SHALL capture fifo_rd_data and rd_inc SHALL be high for exactly this one cycle; the next state SHALL be LAUNCH.
REQ-019 In LAUNCH, tx_data_valid SHALL be high for exactly one cycle and tx_p_data SHALL be held; the next state SHALL be WAIT_BUSY.
REQ-020 Latency from the IDLE qualifying cycle to tx_data_valid SHALL be exactly 2 tx_clk cycles.
REQ-021 WAIT_BUSY SHALL clear its timeout counter on entry, increment it each cycle, and go to WAIT_DONE on busy=1.
REQ-022 If the WAIT_BUSY counter reaches BUSY_TIMEOUT with busy=0, the block SHALL set timeout_err, drop the frame without incrementing frame_count, and go to IDLE.
REQ-023 If busy rises in the same cycle that the timeout is reached, busy SHALL win: no error, and the next state SHALL be WAIT_DONE.
REQ-024 frame_count SHALL increment by 1 on the WAIT_BUSY->WAIT_DONE transition and SHALL wrap from 0xFFFF to 0x0000.
REQ-025 WAIT_DONE SHALL go to GAP on busy=0.
REQ-026 GAP SHALL hold for GAP_CYCLES cycles, then go to IDLE; with GAP_CYCLES=0, GAP SHALL last 0 cycles and WAIT_DONE SHALL go directly to IDLE.
REQ-027 tx_p_data SHALL change only in LOAD.
REQ-028 rd_inc SHALL never assert while empty_flag=1.
REQ-029 At most one rd_inc SHALL occur per frame.
REQ-030 Deasserting tx_enable after IDLE SHALL NOT abort the current frame; the block SHALL return to IDLE and then stop fetching.
REQ-031 timeout_err SHALL clear only on reset.
REQ-032 bridge_idle SHALL be a registered decode of state==IDLE.

Reset
REQ-033 On uart_sync_rst=0, the FSM SHALL go to IDLE immediately and asynchronously.
REQ-034 During reset, rd_inc=0, tx_data_valid=0, tx_p_data=0, frame_count=0, timeout_err=0, bridge_idle=1, and the gap and timeout counters SHALL be 0.
REQ-035 A reset asserted mid-frame SHALL discard the frame, with no further rd_inc or tx_data_valid generated for it.
REQ-036 After reset release, the first fetch SHALL require a fresh IDLE qualifying cycle.

Verification
REQ-037 Single frame: reset release, tx_enable=1, fifo_rd_data=0xA5, empty_flag falls at cycle N -> rd_inc high at N+1, tx_data_valid high at N+2 with tx_p_data=0xA5; busy held high for 10 cycles -> frame_count=1, return to IDLE after GAP_CYCLES.
REQ-038 Back-to-back: 3 words 0x11, 0x22, 0x33 queued -> exactly 3 rd_inc, tx_p_data sequence 0x11/0x22/0x33, each launch at least 1 gap cycle after busy falls, frame_count=3.
REQ-039 Timeout: busy tied 0 -> timeout_err set 255 cycles after launch, frame_count=0, FSM back in IDLE; busy rising at exactly cycle 255 -> no error.
REQ-040 Reset mid-frame: assert uart_sync_rst during WAIT_DONE -> all outputs return to reset values in the same cycle, no extra rd_inc after release while empty_flag=1.
REQ-041 Enable/empty gating: tx_enable=0 with a non-empty FIFO -> no rd_inc for 100 cycles; tx_enable=1 with empty_flag=1 -> no rd_inc; preload frame_count=0xFFFF by running frames -> next frame wraps it to 0x0000.
